// File: rtl/dot_product_pkg.sv
// Shared types and default sizing for the dot-product engine.
package dot_product_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int LEN_W           = 5;
    localparam int ACC_W_DEFAULT   = 20;
    localparam int LEN_MAX_DEFAULT = 16;

endpackage

// File: rtl/multiplier_8bits_version4.sv
// Combinational unsigned 8x8 multiplier built as a sum of shifted partial products.
module multiplier_8bits_version4 (
    output logic [15:0] product,
    input  logic [7:0]  A,
    input  logic [7:0]  B
);

    always_comb begin
        product = '0;
        for (int i = 0; i < 8; i++) begin
            if (B[i]) begin
                product = product + (16'(A) << i);
            end
        end
    end

endmodule

// File: rtl/dot_product_8bits.sv
// Streaming dot-product engine: multiplies accepted operand pairs, registers each
// product, and accumulates a programmable number of terms into a held result.
module dot_product_8bits
    import dot_product_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEFAULT,
    parameter int LEN_MAX = LEN_MAX_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens in a cycle where valid && ready are both high
    // at the rising clock edge; out_valid is held, with result stable, until out_ready.

    state_t             state, state_n;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   len_clamped;
    logic [15:0]        product;
    logic [15:0]        prod_q;
    logic               prod_v;
    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic [ACC_W:0]     sum;
    logic               beat;
    logic               job_start;

    multiplier_8bits_version4 u_mult (
        .product (product),
        .A       (a),
        .B       (b)
    );

    assign len_clamped = (len > LEN_W'(LEN_MAX)) ? LEN_W'(LEN_MAX) : len;
    assign in_ready    = (state == RUN);
    assign beat        = in_valid && in_ready;
    assign job_start   = (state == IDLE) && start;
    // One extra bit catches the carry out of the accumulator for the sticky flag.
    assign sum         = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, prod_q};

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = acc;
    assign overflow  = ovf;
    assign dbg_state = state;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (len_clamped == '0) ? DONE : RUN;
            RUN:     if (beat && remaining == LEN_W'(1)) state_n = DRAIN;
            DRAIN:   state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            prod_q    <= '0;
            prod_v    <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else begin
            state  <= state_n;
            prod_v <= beat;
            if (beat) begin
                prod_q    <= product;
                remaining <= remaining - LEN_W'(1);
            end
            if (job_start) begin
                remaining <= len_clamped;
                acc       <= '0;
                ovf       <= 1'b0;
            end else if (prod_v) begin
                acc <= sum[ACC_W-1:0];
                ovf <= ovf | sum[ACC_W];
            end
        end
    end

endmodule
